// File: rtl/onehot_decoder_seq_if.sv
// Code-input handshake between a code source and the one-hot decoder.
// A push happens on a rising edge when in_valid and in_ready are both high.
interface onehot_decoder_seq_if;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_ready;

  modport master (output in_valid, output in_code, input in_ready);
  modport slave  (input in_valid, input in_code, output in_ready);
endinterface

// File: rtl/onehot_decoder_seq.sv
// Sequenced 3-to-8 one-hot decoder: queued codes become one-hot strobes held
// for HOLD_CYCLES, each followed by at least GAP_CYCLES all-zero cycles.
module onehot_decoder_seq #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  onehot_decoder_seq_if.slave         in_bus,
  output logic [7:0]                  y,
  output logic                        y_valid,
  output logic [2:0]                  y_code,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        busy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
  localparam logic [7:0]    HOLD_LOAD  = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]    GAP_LOAD   = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  logic [2:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    y_q, y_d;
  logic          y_valid_q, y_valid_d;
  logic [2:0]    y_code_q, y_code_d;

  logic          push;
  logic          load;
  logic          fifo_empty;
  logic [2:0]    head;

  // Flush discards any code offered in the same cycle.
  assign push       = in_bus.in_valid && in_ready_q && !flush;
  assign fifo_empty = (level_q == {LW{1'b0}});
  assign head       = mem_q[rd_ptr_q];

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      level_d  = {LW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (load) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, load})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Sequencer next-state: load pops the head and starts a HOLD period.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    y_code_d  = y_code_q;
    load      = 1'b0;
    if (flush) begin
      state_d   = ST_IDLE;
      cnt_d     = 8'd0;
      y_d       = 8'd0;
      y_valid_d = 1'b0;
      y_code_d  = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            load = 1'b0;
          end
        end
        ST_HOLD: begin
          if (cnt_q == 8'd0) begin
            state_d   = ST_GAP;
            cnt_d     = GAP_LOAD;
            y_d       = 8'd0;
            y_valid_d = 1'b0;
            y_code_d  = 3'd0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        ST_GAP: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          cnt_d     = 8'd0;
          y_d       = 8'd0;
          y_valid_d = 1'b0;
          y_code_d  = 3'd0;
        end
      endcase
      if (load) begin
        state_d   = ST_HOLD;
        cnt_d     = HOLD_LOAD;
        y_d       = 8'd1 << head;
        y_valid_d = 1'b1;
        y_code_d  = head;
      end else begin
        load = 1'b0;
      end
    end
  end

  // Status flags are registered from next-state so they track level/state exactly.
  always_comb begin
    in_ready_d = (level_d != FULL_LEVEL);
    busy_d     = (state_d != ST_IDLE) || (level_d != {LW{1'b0}});
  end

  // Code storage; contents are don't-care outside the occupied window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 3'd0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_bus.in_code;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      level_q    <= {LW{1'b0}};
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      y_q        <= 8'd0;
      y_valid_q  <= 1'b0;
      y_code_q   <= 3'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      y_q        <= y_d;
      y_valid_q  <= y_valid_d;
      y_code_q   <= y_code_d;
    end
  end

  assign in_bus.in_ready = in_ready_q;
  assign y               = y_q;
  assign y_valid         = y_valid_q;
  assign y_code          = y_code_q;
  assign level           = level_q;
  assign busy            = busy_q;

endmodule
